// File: rtl/mac_accum_if.sv
// rtl/mac_accum_if.sv - valid/ready operand and result bus for mac_accum
// Operand width comes from the global WIDTH macro (defaults to 8).
`ifndef WIDTH
`define WIDTH 8
`endif

interface mac_accum_if;
  logic                    in_valid;
  logic                    in_ready;
  logic [`WIDTH-1:0]       in_a;
  logic [`WIDTH-1:0]       in_w;
  logic [2*`WIDTH-1:0]     bias;
  logic                    out_valid;
  logic                    out_ready;
  logic [2*`WIDTH-1:0]     out_acc;

  modport master (
    output in_valid, in_a, in_w, bias, out_ready,
    input  in_ready, out_valid, out_acc
  );

  modport slave (
    input  in_valid, in_a, in_w, bias, out_ready,
    output in_ready, out_valid, out_acc
  );
endinterface

// File: rtl/mac_accum.sv
// rtl/mac_accum.sv - streaming signed multiply-accumulate over KLEN beats plus bias
// Define MAC_SATURATE_EN to clamp every accumulate step instead of wrapping.
`ifndef WIDTH
`define WIDTH 8
`endif

module mac_accum #(
  parameter int KLEN = 9
) (
  input  logic         clk,
  input  logic         rst,
  mac_accum_if.slave   bus
);

  localparam int W     = `WIDTH;
  localparam int W2    = 2 * `WIDTH;
  localparam int CNT_W = (KLEN > 1) ? $clog2(KLEN) : 1;

  typedef enum logic {ST_ACC, ST_HOLD} state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [W2-1:0]     r_acc;
  logic [W2-1:0]     r_out_acc;
  logic              r_out_valid;

  logic              w_in_ready;
  logic              w_beat;
  logic              w_last;
  logic [W2-1:0]     w_a_ext;
  logic [W2-1:0]     w_w_ext;
  logic [W2-1:0]     w_prod;
  logic [W2-1:0]     w_base;
  logic [W2-1:0]     w_sum;

  assign w_in_ready = !r_out_valid || bus.out_ready;
  assign w_beat     = bus.in_valid && w_in_ready;
  assign w_last     = (r_cnt == CNT_W'(KLEN - 1));

  // Sign-extend first so the low 2*W bits of the product are exact.
  assign w_a_ext = {{W{bus.in_a[W-1]}}, bus.in_a};
  assign w_w_ext = {{W{bus.in_w[W-1]}}, bus.in_w};
  assign w_prod  = w_a_ext * w_w_ext;

  // cnt is 0 in HOLD, so a beat accepted during an output transfer starts from bias.
  assign w_base  = (r_cnt == '0) ? bus.bias : r_acc;

`ifdef MAC_SATURATE_EN
  logic [W2:0] w_sum_ext;
  assign w_sum_ext = {w_base[W2-1], w_base} + {w_prod[W2-1], w_prod};

  always_comb begin
    w_sum = w_sum_ext[W2-1:0];
    if (w_sum_ext[W2] != w_sum_ext[W2-1]) begin
      w_sum = w_sum_ext[W2] ? {1'b1, {(W2-1){1'b0}}} : {1'b0, {(W2-1){1'b1}}};
    end
  end
`else
  assign w_sum = w_base + w_prod;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_ACC;
      r_cnt       <= '0;
      r_acc       <= '0;
      r_out_acc   <= '0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_ACC: begin
          if (w_beat) begin
            r_acc <= w_sum;
            if (w_last) begin
              r_cnt       <= '0;
              r_out_acc   <= w_sum;
              r_out_valid <= 1'b1;
              r_state     <= ST_HOLD;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
        end
        ST_HOLD: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= ST_ACC;
            if (bus.in_valid) begin
              r_acc <= w_sum;
              // Single-beat windows complete immediately and stay in HOLD.
              if (w_last) begin
                r_out_acc   <= w_sum;
                r_out_valid <= 1'b1;
                r_state     <= ST_HOLD;
              end else begin
                r_cnt <= CNT_W'(1);
              end
            end
          end
        end
        default: begin
          r_state     <= ST_ACC;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_acc   = r_out_acc;

endmodule

// File: tb/tb_mac_accum.sv
// tb/tb_mac_accum.sv - scoreboard bench for mac_accum with KLEN=3 and KLEN=1 instances
// Expected results follow MAC_SATURATE_EN when it is defined.
`ifndef WIDTH
`define WIDTH 8
`endif

module tb_mac_accum;

  localparam int W2 = 2 * `WIDTH;
  localparam longint MAXV = (longint'(1) <<< (W2 - 1)) - 1;
  localparam longint MINV = -(longint'(1) <<< (W2 - 1));

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mac_accum_if if3();
  mac_accum_if if1();

  mac_accum #(.KLEN(3)) u_dut3 (.clk(clk), .rst(rst), .bus(if3));
  mac_accum #(.KLEN(1)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));

  int n_checks = 0;
  int n_errors = 0;
  int n_xfer3  = 0;

  logic [W2-1:0] q3[$];
  logic [W2-1:0] q1[$];

  logic [W2-1:0] m_acc3;
  int            m_cnt3 = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W2-1:0] step(input logic [W2-1:0] base,
                                         input logic [`WIDTH-1:0] a,
                                         input logic [`WIDTH-1:0] w);
    longint s;
    s = longint'($signed(base)) + longint'($signed(a)) * longint'($signed(w));
`ifdef MAC_SATURATE_EN
    if (s > MAXV) s = MAXV;
    else if (s < MINV) s = MINV;
`endif
    return s[W2-1:0];
  endfunction

  always @(negedge clk) begin
    if (!rst && if3.out_valid && if3.out_ready) begin
      n_xfer3++;
      if (q3.size() == 0) check_eq("unexpected_out3", 32'(if3.out_acc), 32'hDEAD);
      else check_eq("acc3", 32'(if3.out_acc), 32'(q3.pop_front()));
    end
    if (!rst && if1.out_valid && if1.out_ready) begin
      if (q1.size() == 0) check_eq("unexpected_out1", 32'(if1.out_acc), 32'hDEAD);
      else check_eq("acc1", 32'(if1.out_acc), 32'(q1.pop_front()));
    end
  end

  task automatic send3(input logic [`WIDTH-1:0] a, input logic [`WIDTH-1:0] w);
    bit ok = 1'b0;
    int n  = 0;
    if3.in_valid = 1'b1;
    if3.in_a = a;
    if3.in_w = w;
    while (!ok && n < 100) begin
      @(negedge clk);
      ok = if3.in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if3.in_valid = 1'b0;
    if (!ok) check_eq("beat3_timeout", 32'(ok), 32'd1);
    else begin
      m_acc3 = (m_cnt3 == 0) ? step(if3.bias, a, w) : step(m_acc3, a, w);
      m_cnt3++;
      if (m_cnt3 == 3) begin
        q3.push_back(m_acc3);
        m_cnt3 = 0;
      end
    end
  endtask

  task automatic send1(input logic [`WIDTH-1:0] a, input logic [`WIDTH-1:0] w);
    bit ok = 1'b0;
    int n  = 0;
    if1.in_valid = 1'b1;
    if1.in_a = a;
    if1.in_w = w;
    while (!ok && n < 100) begin
      @(negedge clk);
      ok = if1.in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if1.in_valid = 1'b0;
    if (!ok) check_eq("beat1_timeout", 32'(ok), 32'd1);
    else q1.push_back(step(if1.bias, a, w));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int x0;
    longint t0;
    logic [W2-1:0] exp_pos, exp_neg;
`ifdef MAC_SATURATE_EN
    exp_pos = 16'h7FFF;
    exp_neg = 16'h8000;
`else
    exp_pos = 16'hBF00;
    exp_neg = 16'h4080;
`endif
    if3.in_valid = 0; if3.in_a = 0; if3.in_w = 0; if3.bias = 0; if3.out_ready = 1;
    if1.in_valid = 0; if1.in_a = 0; if1.in_w = 0; if1.bias = 0; if1.out_ready = 1;

    repeat (2) @(negedge clk);
    check_eq("rst_out_valid", 32'(if3.out_valid), 32'd0);
    check_eq("rst_out_acc",   32'(if3.out_acc),   32'd0);
    check_eq("rst_in_ready",  32'(if3.in_ready),  32'd1);
    check_eq("rst_out_acc1",  32'(if1.out_acc),   32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic window
    if3.bias = 0;
    send3(8'sd2, 8'sd3);
    send3(-8'sd4, 8'sd5);
    check_eq("basic_pre_valid", 32'(if3.out_valid), 32'd0);
    send3(8'sd1, 8'sd1);
    @(negedge clk);
    check_eq("basic_valid", 32'(if3.out_valid), 32'd1);
    check_eq("basic_acc", 32'(if3.out_acc), 32'hFFF3);
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("basic_pulse", 32'(if3.out_valid), 32'd0);
    @(posedge clk); #1;

    // Backpressure
    if3.out_ready = 0;
    send3(8'sd2, 8'sd3);
    send3(-8'sd4, 8'sd5);
    send3(8'sd1, 8'sd1);
    if3.in_valid = 1; if3.in_a = 8'sd9; if3.in_w = 8'sd9;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("bp_valid", 32'(if3.out_valid), 32'd1);
      check_eq("bp_acc", 32'(if3.out_acc), 32'hFFF3);
      check_eq("bp_in_ready", 32'(if3.in_ready), 32'd0);
      @(posedge clk); #1;
    end
    if3.out_ready = 1;
    send3(8'sd1, 8'sd1);
    send3(8'sd2, 8'sd2);
    send3(8'sd3, 8'sd3);
    @(negedge clk);
    check_eq("bp_next_acc", 32'(if3.out_acc), 32'd14);
    @(posedge clk); #1;

    // Streaming with fresh bias per window
    if3.bias = 16'd100;
    x0 = n_xfer3;
    t0 = longint'($time);
    for (int i = 0; i < 6; i++) send3(8'sd1, 8'sd1);
    check_eq("stream_cycles", 32'((longint'($time) - t0) / 10), 32'd6);
    @(negedge clk);
    check_eq("stream_acc", 32'(if3.out_acc), 32'd103);
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("stream_xfers", 32'(n_xfer3 - x0), 32'd2);
    @(posedge clk); #1;

    // Overflow on the single-beat instance, back to back through HOLD
    if1.bias = 16'sd32767;
    send1(8'sd127, 8'sd127);
    if1.bias = 16'h8000;
    @(negedge clk);
    check_eq("pos_ovf", 32'(if1.out_acc), 32'(exp_pos));
    @(posedge clk); #1;
    send1(-8'sd128, 8'sd127);
    @(negedge clk);
    check_eq("neg_ovf", 32'(if1.out_acc), 32'(exp_neg));
    @(posedge clk); #1;

    // Reset mid-window
    if3.bias = 0;
    send3(8'sd1, 8'sd1);
    send3(8'sd1, 8'sd1);
    #2 rst = 1'b1;
    #1;
    check_eq("mid_rst_valid", 32'(if3.out_valid), 32'd0);
    check_eq("mid_rst_acc", 32'(if3.out_acc), 32'd0);
    check_eq("mid_rst_ready", 32'(if3.in_ready), 32'd1);
    #1 rst = 1'b0;
    m_cnt3 = 0;
    @(posedge clk); #1;
    send3(8'sd1, 8'sd1);
    send3(8'sd1, 8'sd1);
    send3(8'sd1, 8'sd1);
    @(negedge clk);
    check_eq("post_rst_acc", 32'(if3.out_acc), 32'd3);

    repeat (3) @(posedge clk);
    #1;
    check_eq("q3_drained", 32'(q3.size()), 32'd0);
    check_eq("q1_drained", 32'(q1.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
